led_matrix_scanner: RTL
=======================

Name: led_matrix_scanner

Overview:
- Avalon-MM slave holding a 5-column x 7-row LED frame; drives the physical matrix by time-multiplexed column scanning.
- Sits directly downstream of the CPU-side column/row PIO stage and replaces software-timed scanning.
- Frame buffer is double-buffered (shadow/active) for tear-free updates; blanking gap between columns suppresses ghosting.

Parameters:
- CLK_DIV, 50000, clk cycles per column slot (blank + drive); 50 MHz gives a 1 kHz column rate. Legal range: CLK_DIV > BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all columns off. Must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational, zero wait states.
- col_n  out  5  column enables, active-low, at most one low.
- row  out  7  row data for the active column, active-high.

Behaviour:
- Register map; a write occurs when chipselect=1 and write_n=0.
  - 0-4: shadow column data [6:0]. RW; reads return the shadow value.
  - 5: CTRL. bit0 EN, bit1 SYNC. RW.
  - 6: STATUS. bit0 FRAME_DONE, sticky, write-1-to-clear. bits[4:2] current column index, read-only.
  - 7: reserved; reads 0, writes ignored.
  - Unused readdata bits read 0.
- Reset:
  - col_n=5'b11111, row=0.
  - Shadow and active buffers 0; CTRL=0; FRAME_DONE=0.
  - Column index 0, slot counter 0, FSM in IDLE.
- Buffer transfer:
  - SYNC=0: a shadow write also updates the active entry in the same cycle, so it is visible on the next drive cycle.
  - SYNC=1: all 5 shadow entries copy to active on the frame wrap cycle only.
- FSM states:
  - IDLE:
    - col_n=11111, row=0, index held at 0.
    - Leaves to BLANK in the cycle after EN reads 1; slot counter set to 0.
  - BLANK:
    - col_n=11111, row=0.
    - After BLANK_CYCLES cycles, goes to DRIVE.
  - DRIVE:
    - col_n[index]=0, others 1; row=active[index], registered.
    - Slot ends when the counter reaches CLK_DIV-1; the FSM then returns to BLANK with the index incremented.
- Frame wrap (index 4 -> 0), same cycle:
  - Index wraps to 0 and FRAME_DONE sets.
  - If SYNC=1, the shadow-to-active copy happens.
- Latency: from EN rising to first column lit is 1 + BLANK_CYCLES cycles. A full frame is 5*CLK_DIV cycles.
- EN cleared mid-scan: the next cycle is IDLE (outputs blanked, index 0, counter 0). Active buffer and FRAME_DONE are kept.
- Simultaneous events:
  - W1C of FRAME_DONE in the same cycle as a frame wrap: set wins, FRAME_DONE=1.
  - Shadow write in the wrap/copy cycle with SYNC=1: the copy takes the old shadow value; the new value appears one frame later.
  - CTRL write in any state takes effect the next cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous).

Optional Feature:
- Macro: LED_MATRIX_FRAME_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) = FRAME_DONE & CTRL bit2 (IRQ_EN).
  - CTRL bit2 becomes RW, reset value 0.
  - irq deasserts the cycle after the W1C write.
- Undefined:
  - No irq port.
  - CTRL bit2 reads 0 and writes are ignored.

Test Plan:
- Use CLK_DIV=8, BLANK_CYCLES=2 for all scenarios.
- Reset, then read address 5 and 6 -> both 0; col_n=11111, row=0 held for 100 cycles with EN=0.
- SYNC=0: write col0=0x55, col1=0x2A; write CTRL=1.
  - Cycles 1-2 after EN: col_n=11111.
  - Then 6 cycles of col_n=11110, row=0x55.
  - Then 2 blank cycles.
  - Then col_n=11101, row=0x2A.
- Run 40 cycles -> FRAME_DONE=1 and STATUS[4:2]=0 at wrap; write 1 to address 6 -> reads 0.
  - Repeat with the W1C landing on the wrap cycle -> reads 1.
- SYNC=1, scanning: write col2=0x7F mid-frame.
  - row for column 2 keeps its old value until after the next wrap.
  - Next frame shows 0x7F.
  - Read of address 2 returns 0x7F immediately.
- Clear EN while col_n=11011 -> next cycle col_n=11111, STATUS[4:2]=0.
  - Re-enable -> scan restarts at column 0 after 2 blank cycles.
- Apply reset_n=0 mid-drive, asynchronous to clk -> col_n=11111, row=0 before the next clk edge; all registers read 0 afterwards.

Source files
------------

// File: rtl/led_matrix_if.sv
// Avalon-MM register bus for the LED matrix scanner.
// Zero-wait-state reads, active-low write strobe.
interface led_matrix_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// 5x7 LED matrix column scanner with shadow/active frame buffers.
// Optional frame interrupt: define LED_MATRIX_FRAME_IRQ_EN.
module led_matrix_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    led_matrix_if.slave bus,
    output logic [4:0]  col_n,
    output logic [6:0]  row
`ifdef LED_MATRIX_FRAME_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [6:0]    shadow [5];
    logic [6:0]    active [5];
    logic          en;
    logic          sync;
    logic          frame_done;
`ifdef LED_MATRIX_FRAME_IRQ_EN
    logic          irq_en;
`endif

    logic wr;
    logic wr_col;
    logic wr_ctrl;
    logic wr_stat;
    logic en_d;
    logic slot_end;
    logic wrap;
    logic unused_bits;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_col  = wr && (bus.address < 3'd5);
    assign wr_ctrl = wr && (bus.address == 3'd5);
    assign wr_stat = wr && (bus.address == 3'd6);

    // A CTRL write is seen by the scanner in its own cycle so that
    // clearing EN blanks the outputs on the very next cycle.
    assign en_d     = wr_ctrl ? bus.writedata[0] : en;
    assign slot_end = (state == DRIVE) && (cnt == CW'(CLK_DIV - 1));
    assign wrap     = slot_end && (idx == 3'd4) && en_d;

    assign unused_bits = ^bus.writedata[31:7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_col)
                shadow[bus.address] <= bus.writedata[6:0];
            // The copy uses the pre-write shadow, so a write landing
            // on the wrap cycle shows up one frame later.
            if (wrap && sync) begin
                for (int i = 0; i < 5; i++)
                    active[i] <= shadow[i];
            end else if (wr_col && !sync) begin
                active[bus.address] <= bus.writedata[6:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en   <= 1'b0;
            sync <= 1'b0;
`ifdef LED_MATRIX_FRAME_IRQ_EN
            irq_en <= 1'b0;
`endif
        end else if (wr_ctrl) begin
            en   <= bus.writedata[0];
            sync <= bus.writedata[1];
`ifdef LED_MATRIX_FRAME_IRQ_EN
            irq_en <= bus.writedata[2];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_done <= 1'b0;
        else if (wrap)
            frame_done <= 1'b1;
        else if (wr_stat && bus.writedata[0])
            frame_done <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            col_n <= 5'b11111;
            row   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt   <= '0;
                    idx   <= '0;
                    col_n <= 5'b11111;
                    row   <= '0;
                    if (en)
                        state <= BLANK;
                end
                BLANK: begin
                    if (!en_d) begin
                        state <= IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                        col_n <= 5'b11111;
                        row   <= '0;
                    end else if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state <= DRIVE;
                        cnt   <= cnt + CW'(1);
                        col_n <= ~(5'b00001 << idx);
                        row   <= active[idx];
                    end else begin
                        cnt   <= cnt + CW'(1);
                        col_n <= 5'b11111;
                        row   <= '0;
                    end
                end
                DRIVE: begin
                    if (!en_d) begin
                        state <= IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                        col_n <= 5'b11111;
                        row   <= '0;
                    end else if (slot_end) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                        col_n <= 5'b11111;
                        row   <= '0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        col_n <= ~(5'b00001 << idx);
                        row   <= active[idx];
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    idx   <= '0;
                    col_n <= 5'b11111;
                    row   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4:
                bus.readdata[6:0] = shadow[bus.address];
            3'd5: begin
                bus.readdata[0] = en;
                bus.readdata[1] = sync;
`ifdef LED_MATRIX_FRAME_IRQ_EN
                bus.readdata[2] = irq_en;
`endif
            end
            3'd6: begin
                bus.readdata[0]   = frame_done;
                bus.readdata[4:2] = idx;
            end
            default: bus.readdata = '0;
        endcase
    end

`ifdef LED_MATRIX_FRAME_IRQ_EN
    assign irq = frame_done & irq_en;
`endif

endmodule
